// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// uart_receiver : 8-bit even-parity UART receiver with single-byte holding
//                 register, error flags and sticky overrun.
// Revision 1.0
// ============================================================================
module uart_receiver #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       rd_en,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int BIT_DELAY = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = BIT_DELAY / 2;
  localparam int CW        = $clog2(BIT_DELAY + 1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_DELAY - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  logic          rx_meta_q, rx_s_q;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          perr_q, perr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          parity_err_q, parity_err_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q, overrun_d;
  logic          commit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    commit       = 1'b0;
    data_d       = data_q;
    valid_d      = valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        // Mid-bit recheck of the start bit rejects short glitches
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_PARITY;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          perr_d  = rx_s_q ^ (^shift_q);
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          commit  = 1'b1;
          state_d = rx_s_q ? S_IDLE : S_RECOVER;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RECOVER: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A read on the commit edge acknowledges the displaced byte, so overrun clears
    if (commit) begin
      data_d       = shift_q;
      parity_err_d = perr_q;
      frame_err_d  = ~rx_s_q;
      valid_d      = 1'b1;
      if (valid_q) overrun_d = ~rd_en;
    end else if (rd_en && valid_q) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// tb_uart_receiver : directed frames against a frame-level expectation model.
// Revision 1.0
// ============================================================================
module tb_uart_receiver;

  localparam int CLK_FREQ  = 16;
  localparam int BAUD_RATE = 1;
  localparam int BIT       = CLK_FREQ / BAUD_RATE;
  localparam int HALF      = BIT / 2;
  // Edges from the first low line sample to the commit edge:
  // 2 synchronizer edges, half a bit to mid-start, then 10 bit periods.
  localparam int COMMIT_LAT = 2 + HALF + 10 * BIT;

  logic       clk, rst_n, rx, rd_en;
  logic [7:0] data_out;
  logic       valid, parity_err, frame_err, overrun, busy;

  uart_receiver #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .rd_en(rd_en),
    .data_out(data_out), .valid(valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned at;
    logic [7:0]  d;
    logic        pe;
    logic        fe;
  } ev_t;

  ev_t         evq[$];
  ev_t         ev;
  int unsigned cyc = 0;
  logic [7:0]  m_data;
  logic        m_valid, m_pe, m_fe, m_ovr;
  bit          model_ok = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic even_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) if (b[i]) ones++;
    return logic'(ones % 2);
  endfunction

  // Holding-register model updated once per edge from queued frame outcomes
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      evq.delete();
      m_data = 8'h00; m_valid = 0; m_pe = 0; m_fe = 0; m_ovr = 0;
      model_ok = 1;
    end else if (evq.size() > 0 && evq[0].at == cyc) begin
      ev = evq.pop_front();
      if (m_valid) m_ovr = rd_en ? 1'b0 : 1'b1;
      m_data = ev.d; m_pe = ev.pe; m_fe = ev.fe; m_valid = 1;
    end else if (rd_en && m_valid) begin
      m_valid = 0; m_ovr = 0;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      checks++;
      if ({data_out, valid, parity_err, frame_err, overrun} !==
          {m_data, m_valid, m_pe, m_fe, m_ovr}) begin
        errors++;
        $display("FAIL outputs cyc=%0d actual d=%h v=%b pe=%b fe=%b ov=%b required d=%h v=%b pe=%b fe=%b ov=%b",
                 cyc, data_out, valid, parity_err, frame_err, overrun,
                 m_data, m_valid, m_pe, m_fe, m_ovr);
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // Called at #1 after an edge; drives a full frame and queues its outcome
  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop,
                            input bit ack, input int low_after);
    ev_t e;
    e.at = cyc + 1 + COMMIT_LAT;
    e.d  = b;
    e.pe = !par_ok;
    e.fe = !stop;
    evq.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(par_ok ? even_par(b) : ~even_par(b));
    rx = stop;
    repeat (BIT - 6) @(posedge clk);
    #1 rd_en = ack;
    @(posedge clk);
    #1 rd_en = 1'b0;
    repeat (5 + low_after) @(posedge clk);
    #1 rx = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_pulse;
    rd_en = 1'b1;
    @(posedge clk);
    #1 rd_en = 1'b0;
    idle(2);
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    check({name, "_data"}, data_out, 8'h00);
    check({name, "_flags"}, {3'b0, valid, parity_err, frame_err, overrun, busy}, 8'h00);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; rx = 1'b1; rd_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check_reset_state("reset");

    // Clean frame, hand-computed result
    send_frame(8'hA5, 1, 1, 0, 0);
    @(negedge clk);
    check("a5_data", data_out, 8'hA5);
    check("a5_flags", {4'b0, valid, parity_err, frame_err, overrun}, 8'b1000);
    check("a5_model", m_data, 8'hA5);
    check("a5_busy", {7'b0, busy}, 8'h00);
    @(posedge clk); #1;
    read_pulse();
    check("a5_read_valid", {7'b0, valid}, 8'h00);

    // Wrong parity bit on 0x01
    send_frame(8'h01, 0, 1, 0, 0);
    @(negedge clk);
    check("p01_data", data_out, 8'h01);
    check("p01_flags", {4'b0, valid, parity_err, frame_err, overrun}, 8'b1100);
    @(posedge clk); #1;
    read_pulse();

    // Stop bit low, line held low 40 cycles from stop-bit start
    send_frame(8'h3C, 1, 0, 0, 24);
    @(negedge clk);
    check("f3c_busy_low", {7'b0, busy}, 8'h01);
    check("f3c_flags", {4'b0, valid, parity_err, frame_err, overrun}, 8'b1010);
    repeat (4) @(negedge clk);
    check("f3c_busy_idle", {7'b0, busy}, 8'h00);
    @(posedge clk); #1;
    read_pulse();

    // 4-cycle glitch must be rejected
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(20);
    check("glitch_busy", {7'b0, busy}, 8'h00);
    check("glitch_valid", {7'b0, valid}, 8'h00);
    send_frame(8'h5A, 1, 1, 0, 0);
    @(negedge clk);
    check("g5a_data", data_out, 8'h5A);
    @(posedge clk); #1;
    read_pulse();

    // Overrun: newest byte wins, read clears valid and overrun
    send_frame(8'h11, 1, 1, 0, 0);
    idle(3);
    send_frame(8'h22, 1, 1, 0, 0);
    @(negedge clk);
    check("ovr_data", data_out, 8'h22);
    check("ovr_flags", {4'b0, valid, parity_err, frame_err, overrun}, 8'b1001);
    @(posedge clk); #1;
    read_pulse();
    check("ovr_read_data", data_out, 8'h22);
    check("ovr_read_flags", {4'b0, valid, parity_err, frame_err, overrun}, 8'b0000);

    // Read on the commit edge with overrun pending
    send_frame(8'h33, 1, 1, 0, 0);
    idle(3);
    send_frame(8'h44, 1, 1, 0, 0);
    idle(3);
    send_frame(8'h55, 1, 1, 1, 0);
    @(negedge clk);
    check("ack_data", data_out, 8'h55);
    check("ack_flags", {4'b0, valid, parity_err, frame_err, overrun}, 8'b1000);
    @(posedge clk); #1;
    read_pulse();
    read_pulse();
    check("rd_idle_valid", {7'b0, valid}, 8'h00);

    // Reset mid-DATA of 0xFF with an unread byte present
    send_frame(8'h77, 1, 1, 0, 0);
    idle(3);
    drive_bit(1'b0);
    rx = 1'b1;
    idle(40);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    check_reset_state("midrst");
    idle(30);
    check("midrst_busy", {7'b0, busy}, 8'h00);
    send_frame(8'h81, 1, 1, 0, 0);
    @(negedge clk);
    check("r81_data", data_out, 8'h81);
    check("r81_flags", {4'b0, valid, parity_err, frame_err, overrun}, 8'b1000);
    @(posedge clk); #1;
    idle(5);

    if (evq.size() != 0) begin
      errors++;
      $display("FAIL pending_events actual=%0d required=0", evq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
